// File: rtl/serial_frame_rx.sv
// serial_frame_rx: receives start / data (MSB first) / optional even parity / stop
// frames from a gated serial stream and hands each good word to a one-entry
// valid/ready output buffer. Errors are reported as single-cycle pulses.
module serial_frame_rx #(
    parameter int DATA_W    = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_din,
    input  logic              s_vld,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Five bits cover the largest legal payload (16 bits).
    localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);

    state_t            state_reg,      state_next;
    logic [4:0]        cnt_reg,        cnt_next;
    logic [DATA_W-1:0] shreg_reg,      shreg_next;
    logic              par_bad_reg,    par_bad_next;
    logic [DATA_W-1:0] out_data_reg,   out_data_next;
    logic              out_valid_reg,  out_valid_next;
    logic              frame_err_reg,  frame_err_next;
    logic              parity_err_reg, parity_err_next;
    logic              overrun_reg,    overrun_next;

    // State and output registers; reset clears everything, including a pending word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            shreg_reg      <= '0;
            par_bad_reg    <= 1'b0;
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            shreg_reg      <= shreg_next;
            par_bad_reg    <= par_bad_next;
            out_data_reg   <= out_data_next;
            out_valid_reg  <= out_valid_next;
            frame_err_reg  <= frame_err_next;
            parity_err_reg <= parity_err_next;
            overrun_reg    <= overrun_next;
        end
    end

    // Next-state logic: the frame machine only moves on s_vld cycles, while the
    // output buffer drains on out_ready independently of the serial side.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        shreg_next      = shreg_reg;
        par_bad_next    = par_bad_reg;
        out_data_next   = out_data_reg;
        out_valid_next  = out_valid_reg;
        frame_err_next  = 1'b0;
        parity_err_next = 1'b0;
        overrun_next    = 1'b0;

        // An accepted word leaves the buffer; a delivery below may refill it.
        if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end

        if (s_vld) begin
            case (state_reg)
                IDLE: begin
                    // Idle-line ones are ignored; a zero is the start bit.
                    if (!s_din) begin
                        state_next   = DATA;
                        cnt_next     = '0;
                        par_bad_next = 1'b0;
                    end
                end
                DATA: begin
                    shreg_next = {shreg_reg[DATA_W-2:0], s_din};
                    cnt_next   = cnt_reg + 5'd1;
                    if (cnt_reg == LAST_BIT) begin
                        if (PARITY_EN) begin
                            state_next = PARITY;
                        end else begin
                            state_next = STOP;
                        end
                    end
                end
                PARITY: begin
                    // Even parity: data bits plus parity bit must XOR to zero.
                    par_bad_next = (^shreg_reg) ^ s_din;
                    state_next   = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    // Framing error takes priority so only one pulse can fire.
                    if (!s_din) begin
                        frame_err_next = 1'b1;
                    end else if (par_bad_reg) begin
                        parity_err_next = 1'b1;
                    end else if (!out_valid_reg || out_ready) begin
                        out_data_next  = shreg_reg;
                        out_valid_next = 1'b1;
                    end else begin
                        overrun_next = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign out_data   = out_data_reg;
    assign out_valid  = out_valid_reg;
    assign frame_err  = frame_err_reg;
    assign parity_err = parity_err_reg;
    assign overrun    = overrun_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Testbench for serial_frame_rx: directed scenarios plus randomized frames,
// checked every cycle against a frame-level reference model.
module tb_serial_frame_rx;

    localparam int DATA_W    = 8;
    localparam bit PARITY_EN = 1'b1;
    localparam int FRAME_LEN = DATA_W + 2 + (PARITY_EN ? 1 : 0);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_din = 1'b1;
    logic              s_vld = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              frame_err;
    logic              parity_err;
    logic              overrun;
    logic              busy;

    serial_frame_rx #(.DATA_W(DATA_W), .PARITY_EN(PARITY_EN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_din      (s_din),
        .s_vld      (s_vld),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: expected outputs after the most recent clock edge.
    logic              exp_valid, exp_ferr, exp_perr, exp_ovr, exp_busy;
    logic [DATA_W-1:0] exp_data;
    logic              m_active;
    logic              m_bits[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_ferr  = 1'b0;
        exp_perr  = 1'b0;
        exp_ovr   = 1'b0;
        exp_busy  = 1'b0;
        m_active  = 1'b0;
        m_bits.delete();
    endtask

    // Frame-level model: collect sampled bits from a start bit until a full
    // frame is in hand, then judge it as a whole.
    task automatic model_update(input logic v, input logic d, input logic r);
        logic              good;
        logic              bad_par;
        logic [DATA_W-1:0] word;
        int                ones;
        good     = 1'b0;
        word     = '0;
        exp_ferr = 1'b0;
        exp_perr = 1'b0;
        exp_ovr  = 1'b0;
        if (v) begin
            if (!m_active) begin
                if (d == 1'b0) begin
                    m_active = 1'b1;
                    m_bits.delete();
                    m_bits.push_back(d);
                end
            end else begin
                m_bits.push_back(d);
                if (m_bits.size() == FRAME_LEN) begin
                    ones = 0;
                    for (int i = 0; i < DATA_W; i++) begin
                        word = {word[DATA_W-2:0], m_bits[1+i]};
                        ones += int'(m_bits[1+i]);
                    end
                    if (PARITY_EN) ones += int'(m_bits[1+DATA_W]);
                    bad_par = PARITY_EN && (ones % 2 == 1);
                    if (m_bits[FRAME_LEN-1] == 1'b0) exp_ferr = 1'b1;
                    else if (bad_par)                exp_perr = 1'b1;
                    else                             good     = 1'b1;
                    m_active = 1'b0;
                end
            end
        end
        if (good && (!exp_valid || r)) begin
            exp_valid = 1'b1;
            exp_data  = word;
        end else begin
            if (good) exp_ovr = 1'b1;
            if (exp_valid && r) exp_valid = 1'b0;
        end
        exp_busy = m_active;
    endtask

    // One clock: check outputs from the previous edge, then drive new inputs.
    task automatic step(input logic v, input logic d, input logic r);
        @(negedge clk);
        check_eq("out_valid",  out_valid,  exp_valid);
        check_eq("out_data",   out_data,   exp_data);
        check_eq("frame_err",  frame_err,  exp_ferr);
        check_eq("parity_err", parity_err, exp_perr);
        check_eq("overrun",    overrun,    exp_ovr);
        check_eq("busy",       busy,       exp_busy);
        s_vld     = v;
        s_din     = v ? d : logic'($urandom_range(1));
        out_ready = r;
        model_update(v, s_din, r);
    endtask

    function automatic logic pick(input int mode);
        if (mode == 2) return logic'($urandom_range(1));
        return (mode != 0);
    endfunction

    // Send one frame; gaps<0 means a random number of s_vld=0 cycles per bit.
    task automatic send_frame(input logic [DATA_W-1:0] data, input bit bad_par, input bit bad_stop,
                              input int gaps, input int rdy_body, input int rdy_stop);
        logic fb[$];
        int   ng;
        fb.push_back(1'b0);
        for (int i = DATA_W - 1; i >= 0; i--) fb.push_back(data[i]);
        if (PARITY_EN) fb.push_back((^data) ^ bad_par);
        fb.push_back(~bad_stop);
        for (int k = 0; k < fb.size(); k++) begin
            ng = (k == 0) ? 0 : ((gaps < 0) ? int'($urandom_range(0, 3)) % 3 : gaps);
            for (int g = 0; g < ng; g++) step(1'b0, 1'b0, pick(rdy_body));
            step(1'b1, fb[k], (k == fb.size() - 1) ? pick(rdy_stop) : pick(rdy_body));
        end
        $display("[TB] frame data=%0h bad_par=%0d bad_stop=%0d", data, bad_par, bad_stop);
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any edge.
    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        s_vld = 1'b0;
        #1;
        check_eq("rst_busy",       busy,       0);
        check_eq("rst_out_valid",  out_valid,  0);
        check_eq("rst_out_data",   out_data,   0);
        check_eq("rst_frame_err",  frame_err,  0);
        check_eq("rst_parity_err", parity_err, 0);
        check_eq("rst_overrun",    overrun,    0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and idle-line ones ignored.
        repeat (3) step(1'b1, 1'b1, 1'b1);

        // 0xA5 back to back, then with two-cycle gaps between bits.
        send_frame(8'hA5, 0, 0, 0, 1, 1);
        repeat (3) step(1'b1, 1'b1, 1'b1);
        send_frame(8'hA5, 0, 0, 2, 1, 1);
        repeat (3) step(1'b0, 1'b0, 1'b1);

        // Parity and framing errors.
        send_frame(8'hA5, 1, 0, 0, 1, 1);
        repeat (2) step(1'b1, 1'b1, 1'b1);
        send_frame(8'hA5, 0, 1, 0, 1, 1);
        send_frame(8'hA5, 1, 1, 0, 1, 1);
        repeat (2) step(1'b1, 1'b1, 1'b1);

        // Back-pressure: second frame overruns, then drain.
        send_frame(8'h3C, 0, 0, 0, 0, 0);
        send_frame(8'hC3, 0, 0, 1, 0, 0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0);

        // Simultaneous accept and new delivery keeps out_valid high.
        send_frame(8'h11, 0, 0, 0, 0, 0);
        send_frame(8'h22, 0, 0, 0, 0, 1);
        repeat (2) step(1'b1, 1'b1, 1'b1);

        // Reset after four data bits with a pending word, then a clean 0x5A.
        send_frame(8'h77, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, logic'(i % 2), 1'b0);
        async_reset();
        send_frame(8'h5A, 0, 0, 0, 1, 1);
        repeat (2) step(1'b1, 1'b1, 1'b1);

        // Randomized frames, gaps, idle ones and back-pressure.
        for (int f = 0; f < 150; f++) begin
            int idle;
            idle = int'($urandom_range(0, 3));
            for (int i = 0; i < idle; i++) step(logic'($urandom_range(1)), 1'b1, logic'($urandom_range(1)));
            send_frame(DATA_W'($urandom), ($urandom_range(7) == 0), ($urandom_range(7) == 0), -1, 2, 2);
        end
        repeat (4) step(1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, number of data bits per frame (legal range 2..16).
REQ-002 SHALL have parameter PARITY_EN, default 1: 1 means an even-parity bit follows the data bits; 0 means no parity bit.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; the clock and reset are the first two ports listed below.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port s_din  input  1  serial bit from the upstream shift stage (its MSB-side serial output).
REQ-007 SHALL have port s_vld  input  1  s_din is sampled only in cycles where s_vld=1.
REQ-008 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-009 SHALL have port out_data  output  DATA_W  assembled frame payload.
REQ-010 SHALL have port out_valid  output  1  out_data holds an unaccepted word.
REQ-011 SHALL have ports frame_err, parity_err, overrun  output  1 each  one-cycle error pulses.
REQ-012 SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-013 SHALL use frame format: start bit (0), DATA_W data bits MSB first, parity bit if PARITY_EN, stop bit (1).
REQ-014 SHALL implement states IDLE, DATA, PARITY, STOP, with all transitions taken only on s_vld=1 cycles.
REQ-015 IDLE: s_vld=1 with s_din=0 SHALL go to DATA with the bit counter cleared; s_vld=1 with s_din=1 SHALL be ignored.
REQ-016 DATA: each sampled bit SHALL shift in as shreg <= {shreg[DATA_W-2:0], s_din}; after the DATA_W-th bit, SHALL go to PARITY if PARITY_EN, else STOP.
REQ-017 PARITY: SHALL record a parity mismatch if XOR of the data bits and the parity bit is 1; SHALL then go to STOP.
REQ-018 STOP: SHALL always return to IDLE after sampling the stop bit.
REQ-019 STOP with s_din=0 SHALL pulse frame_err for one cycle, SHALL discard the word, and SHALL NOT pulse parity_err.
REQ-020 STOP with s_din=1 and a parity mismatch SHALL pulse parity_err for one cycle and SHALL discard the word.
REQ-021 STOP with s_din=1 and no mismatch SHALL deliver the word if the buffer is free, where free means out_valid=0, or out_valid=1 with out_ready=1 in the same cycle.
REQ-022 Delivery SHALL load out_data and set out_valid=1, visible in the cycle after the stop-bit sample (latency 1 clock).
REQ-023 A good frame completing while the buffer is not free SHALL pulse overrun for one cycle, SHALL drop the new word, and SHALL leave out_data unchanged.
REQ-024 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 out_valid SHALL clear the cycle after out_valid=1 and out_ready=1, unless a new word loads in that same cycle, in which case out_valid SHALL stay 1 with the new data.
REQ-026 s_vld=0 cycles SHALL freeze the state machine, counter and shift register; gaps of any length SHALL be allowed.
REQ-027 Frame reception SHALL be independent of out_ready; back-pressure SHALL never stall sampling.
REQ-028 At most one error pulse SHALL be asserted in any cycle.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for a clock edge, force state IDLE, counter 0, shreg 0, out_data 0, out_valid 0, frame_err 0, parity_err 0, overrun 0 and busy 0.
REQ-030 Reset asserted mid-frame SHALL abandon the partial frame with no error pulse; after release, the next s_din=0 sample SHALL be treated as a start bit.
REQ-031 Reset SHALL clear any pending undelivered word.

Verification
REQ-032 Scenario: DATA_W=8, PARITY_EN=1, bits 0,1,0,1,0,0,1,0,1,0,1 on consecutive s_vld cycles, out_ready=1 -> out_data=0xA5 and out_valid=1 for exactly one cycle, starting one cycle after the stop sample; no error pulses.
REQ-033 Scenario: same frame with s_vld toggling 1,0,0,1,... between bits -> identical result, with out_valid asserted one cycle after the stop sample.
REQ-034 Scenario: 0xA5 frame with parity bit 1 -> parity_err pulses once, out_valid stays 0; the same frame with stop bit 0 -> frame_err pulses once, parity_err stays 0.
REQ-035 Scenario: out_ready=0, frames 0x3C then 0xC3 -> out_data=0x3C held, overrun pulses at the end of the second frame; raising out_ready then clears out_valid next cycle.
REQ-036 Scenario: rst_n pulled low after 4 data bits -> busy=0 and all outputs 0 asynchronously; after release, a full 0x5A frame is received correctly.
REQ-037 Scenario: out_valid=1 with out_ready=1 in the same cycle a new good frame completes -> out_valid stays 1 with the new word; no overrun pulse.
